// File: rtl/perf_block_recorder.sv
// Per-block performance recorder: counts cycles and PEB/MAC strobes between start/finish
// events and streams {idx, cyc, peb, mac[, total]} records as word bursts. Option: PERF_TOTAL_EN.
module perf_block_recorder #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     blk_start,
  input  logic                     blk_finish,
  input  logic                     inc_peb,
  input  logic                     inc_mac,
  output logic                     rec_val,
  input  logic                     rec_rdy,
  output logic [CNT_W-1:0]         rec_data,
  output logic                     rec_last,
  output logic                     busy,
  output logic [15:0]              drop_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);

`ifdef PERF_TOTAL_EN
  localparam int unsigned NW = 5;
`else
  localparam int unsigned NW = 4;
`endif
  localparam int unsigned WP_W  = $clog2(NW);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != '1)) return v + CNT_W'(1);
    return v;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d, peb_q, peb_d, mac_q, mac_d;
  logic [CNT_W-1:0]   cyc_run, peb_run, mac_run;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               push_req, push, pop, drop, full, xfer;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q;
  logic [WP_W-1:0]    wptr_q;
  logic [15:0]        drop_q;
  logic [CNT_W-1:0]   rec_words [NW];
  logic [CNT_W-1:0]   mem [DEPTH][NW];

`ifdef PERF_TOTAL_EN
  logic [CNT_W-1:0]   total_q, total_d;

  assign total_d = sat_inc(total_q, 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) total_q <= '0;
    else        total_q <= total_d;
  end
`endif

  // Running values include the current cycle, so a finish records its own cycle.
  assign cyc_run = sat_inc(cyc_q, 1'b1);
  assign peb_run = sat_inc(peb_q, inc_peb);
  assign mac_run = sat_inc(mac_q, inc_mac);

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    peb_d    = peb_q;
    mac_d    = mac_q;
    idx_d    = idx_q;
    push_req = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (blk_start) begin
          state_d = StRun;
          cyc_d   = CNT_W'(1);
          peb_d   = CNT_W'(inc_peb);
          mac_d   = CNT_W'(inc_mac);
        end
      end
      StRun: begin
        cyc_d = cyc_run;
        peb_d = peb_run;
        mac_d = mac_run;
        if (blk_finish) begin
          push_req = 1'b1;
          idx_d    = idx_q + IDX_W'(1);
          if (blk_start) begin
            cyc_d = CNT_W'(1);
            peb_d = CNT_W'(inc_peb);
            mac_d = CNT_W'(inc_mac);
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rec_words[0] = CNT_W'(idx_q);
    rec_words[1] = cyc_run;
    rec_words[2] = peb_run;
    rec_words[3] = mac_run;
`ifdef PERF_TOTAL_EN
    rec_words[4] = total_d;
`endif
  end

  // Fullness uses the registered level; a pop in the same cycle does not make room.
  assign full = (level_q == LVL_W'(DEPTH));
  assign push = push_req && !full;
  assign drop = push_req && full;

  assign rec_val  = (level_q != '0);
  assign rec_last = rec_val && (wptr_q == WP_W'(NW - 1));
  assign xfer     = rec_val && rec_rdy;
  assign pop      = xfer && rec_last;

  always_comb begin
    rec_data = '0;
    if (rec_val) begin
      for (int i = 0; i < NW; i++) begin
        if (wptr_q == WP_W'(i)) rec_data = mem[rd_ptr_q][i];
      end
    end
  end

  // Storage is flushed by pointer reset only; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < NW; i++) mem[wr_ptr_q][i] <= rec_words[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cyc_q    <= '0;
      peb_q    <= '0;
      mac_q    <= '0;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      wptr_q   <= '0;
      drop_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      peb_q   <= peb_d;
      mac_q   <= mac_d;
      idx_q   <= idx_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
      if (xfer) wptr_q <= rec_last ? '0 : wptr_q + WP_W'(1);
      if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  assign busy       = (state_q == StRun);
  assign drop_cnt   = drop_q;
  assign fifo_level = level_q;

endmodule
